// File: rtl/intersection_controller.sv
// Two-road intersection controller: rests in main green, serves the side
// street on a vehicle request or a latched pedestrian request, and enforces
// minimum green, fixed yellow and all-red clearance intervals.
module intersection_controller #(
  parameter int unsigned GREEN_MIN = 10,
  parameter int unsigned YELLOW_T  = 3,
  parameter int unsigned ALLRED_T  = 2,
  parameter int unsigned SIDE_T    = 6,
  parameter int unsigned CNT_W     = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       side_req,
  input  logic       ped_req,
  output logic [2:0] main_light,
  output logic [2:0] side_light,
  output logic       walk,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    MAIN_GREEN  = 3'd0,
    MAIN_YELLOW = 3'd1,
    ALLRED_1    = 3'd2,
    SIDE_GREEN  = 3'd3,
    SIDE_YELLOW = 3'd4,
    ALLRED_2    = 3'd5
  } state_e;

  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] GREEN  = 3'b001;

  // Timer reload values: a state of duration D loads D-1 on entry.
  localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] ALLRED_LD = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] SIDE_LD   = CNT_W'(SIDE_T - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             ped_pending_q, ped_pending_d;
  logic             walk_active_q, walk_active_d;
  logic             timer_zero;

  assign timer_zero = (timer_q == '0);

  // Next-state, timer and pedestrian-latch logic.
  always_comb begin
    state_d       = state_q;
    timer_d       = timer_zero ? '0 : timer_q - CNT_W'(1);
    ped_pending_d = ped_pending_q;
    walk_active_d = walk_active_q;
    case (state_q)
      MAIN_GREEN: begin
        if (timer_zero && (side_req || ped_pending_q)) begin
          state_d = MAIN_YELLOW;
          timer_d = YELLOW_LD;
        end
      end
      MAIN_YELLOW: begin
        if (timer_zero) begin
          state_d = ALLRED_1;
          timer_d = ALLRED_LD;
        end
      end
      ALLRED_1: begin
        if (timer_zero) begin
          state_d       = SIDE_GREEN;
          timer_d       = SIDE_LD;
          ped_pending_d = 1'b0;
          walk_active_d = ped_pending_q;
        end
      end
      SIDE_GREEN: begin
        if (timer_zero) begin
          state_d       = SIDE_YELLOW;
          timer_d       = YELLOW_LD;
          walk_active_d = 1'b0;
        end
      end
      SIDE_YELLOW: begin
        if (timer_zero) begin
          state_d = ALLRED_2;
          timer_d = ALLRED_LD;
        end
      end
      ALLRED_2: begin
        if (timer_zero) begin
          state_d = MAIN_GREEN;
          timer_d = GREEN_LD;
        end
      end
      default: begin
        state_d       = ALLRED_2;
        timer_d       = ALLRED_LD;
        walk_active_d = 1'b0;
      end
    endcase
    // A new press wins over the clear at service start, so it is kept for the next service.
    if (ped_req) ped_pending_d = 1'b1;
  end

  // State registers with asynchronous active-low reset into ALLRED_2.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ALLRED_2;
      timer_q       <= ALLRED_LD;
      ped_pending_q <= 1'b0;
      walk_active_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      ped_pending_q <= ped_pending_d;
      walk_active_q <= walk_active_d;
    end
  end

  // Light heads, walk and phase decoded from the registered state.
  always_comb begin
    main_light = RED;
    side_light = RED;
    walk       = 1'b0;
    phase      = state_q;
    case (state_q)
      MAIN_GREEN:  main_light = GREEN;
      MAIN_YELLOW: main_light = YELLOW;
      SIDE_GREEN: begin
        side_light = GREEN;
        walk       = walk_active_q;
      end
      SIDE_YELLOW: side_light = YELLOW;
      default: begin
        main_light = RED;
        side_light = RED;
      end
    endcase
  end

endmodule

// File: tb/tb_intersection_controller.sv
// Self-checking bench for intersection_controller: directed scenarios with
// literal expectations plus randomized traffic against a behavioural model.
module tb_intersection_controller;

  localparam int GREEN_MIN = 10;
  localparam int YELLOW_T  = 3;
  localparam int ALLRED_T  = 2;
  localparam int SIDE_T    = 6;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       side_req = 1'b0;
  logic       ped_req = 1'b0;
  logic [2:0] main_light, side_light, phase;
  logic       walk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;
  int edge_n   = 0;
  int ph_log [0:63];
  int wk_log [0:63];

  intersection_controller #(
    .GREEN_MIN(GREEN_MIN), .YELLOW_T(YELLOW_T), .ALLRED_T(ALLRED_T),
    .SIDE_T(SIDE_T), .CNT_W(8)
  ) dut (
    .clk(clk), .reset_n(reset_n), .side_req(side_req), .ped_req(ped_req),
    .main_light(main_light), .side_light(side_light), .walk(walk), .phase(phase)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase index, cycles spent in the phase, pedestrian latch.
  int m_ph;
  int m_el;
  bit m_pend;
  bit m_walk;

  function automatic int dur_of(input int p);
    case (p)
      0:       return GREEN_MIN;
      1, 4:    return YELLOW_T;
      3:       return SIDE_T;
      default: return ALLRED_T;
    endcase
  endfunction

  function automatic int exp_main(input int p);
    case (p)
      0:       return 3'b001;
      1:       return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  function automatic int exp_side(input int p);
    case (p)
      3:       return 3'b001;
      4:       return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  always @(posedge clk or negedge reset_n) begin : model
    bit adv;
    if (!reset_n) begin
      m_ph   <= 5;
      m_el   <= 0;
      m_pend <= 1'b0;
      m_walk <= 1'b0;
    end else begin
      adv = (m_el >= dur_of(m_ph) - 1) && (m_ph != 0 || side_req || m_pend);
      m_ph <= adv ? (m_ph + 1) % 6 : m_ph;
      m_el <= adv ? 0 : (m_el < 1000 ? m_el + 1 : m_el);
      if (adv && m_ph == 2) m_walk <= m_pend;
      else if (adv && m_ph == 3) m_walk <= 1'b0;
      if (ped_req) m_pend <= 1'b1;
      else if (adv && m_ph == 2) m_pend <= 1'b0;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("main_light", main_light, exp_main(m_ph));
      check("side_light", side_light, exp_side(m_ph));
      check("walk", walk, (m_ph == 3) && m_walk);
      check("phase", phase, m_ph);
      check("both_heads_open", (main_light != 3'b100) && (side_light != 3'b100), 0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    edge_n++;
    if (edge_n < 64) begin
      ph_log[edge_n] = phase;
      wk_log[edge_n] = walk;
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Asynchronous reset pulse between clock edges; edge count restarts at release.
  task automatic do_reset(input bit lit);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    if (lit) begin
      check("rst_main", main_light, 3'b100);
      check("rst_side", side_light, 3'b100);
      check("rst_walk", walk, 0);
      check("rst_phase", phase, 5);
    end
    @(negedge clk);
    #2;
    reset_n = 1'b1;
    edge_n = 0;
  endtask

  initial begin
    #1 reset_n = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    #2 reset_n = 1'b1;
    edge_n = 0;

    // Rest: no requests for 100 cycles.
    steps(100);
    check("rest_e1_phase", ph_log[1], 5);
    check("rest_e2_phase", ph_log[2], 0);
    check("rest_e63_phase", ph_log[63], 0);
    check("rest_end_main", main_light, 3'b001);
    check("rest_end_side", side_light, 3'b100);

    // Short request during minimum green is ignored.
    do_reset(1'b1);
    steps(2);
    side_req = 1'b1;
    steps(6);
    side_req = 1'b0;
    steps(32);
    check("short_e12_phase", ph_log[12], 0);
    check("short_e40_phase", ph_log[40], 0);

    // Side service with side_req held high, then reset mid-SIDE_GREEN.
    do_reset(1'b0);
    side_req = 1'b1;
    steps(45);
    check("svc_e11", ph_log[11], 0);
    check("svc_e12", ph_log[12], 1);
    check("svc_e14", ph_log[14], 1);
    check("svc_e15", ph_log[15], 2);
    check("svc_e16", ph_log[16], 2);
    check("svc_e17", ph_log[17], 3);
    check("svc_e22", ph_log[22], 3);
    check("svc_e23", ph_log[23], 4);
    check("svc_e26", ph_log[26], 5);
    check("svc_e28", ph_log[28], 0);
    check("svc_e37", ph_log[37], 0);
    check("svc_e38", ph_log[38], 1);
    check("svc_e43", ph_log[43], 3);
    check("svc_e45", phase, 3);
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst_main", main_light, 3'b100);
    check("midrst_side", side_light, 3'b100);
    check("midrst_walk", walk, 0);
    check("midrst_phase", phase, 5);
    side_req = 1'b0;
    @(negedge clk);
    #2;
    reset_n = 1'b1;
    edge_n = 0;
    steps(4);
    check("midrst_e1", ph_log[1], 5);
    check("midrst_e2", ph_log[2], 0);

    // Single pedestrian pulse at edge 5.
    do_reset(1'b0);
    steps(4);
    ped_req = 1'b1;
    step();
    ped_req = 1'b0;
    steps(35);
    check("ped_e11", ph_log[11], 0);
    check("ped_e12", ph_log[12], 1);
    check("ped_walk16", wk_log[16], 0);
    check("ped_walk17", wk_log[17], 1);
    check("ped_walk22", wk_log[22], 1);
    check("ped_walk23", wk_log[23], 0);
    check("ped_e40", ph_log[40], 0);
    check("ped_pending_after", dut.ped_pending_q, 0);

    // Pedestrian press during walk is kept for a second service.
    do_reset(1'b0);
    steps(4);
    ped_req = 1'b1;
    step();
    ped_req = 1'b0;
    steps(13);
    ped_req = 1'b1;
    step();
    ped_req = 1'b0;
    steps(31);
    check("ped2_walk19", wk_log[19], 1);
    check("ped2_walk22", wk_log[22], 1);
    check("ped2_walk23", wk_log[23], 0);
    check("ped2_e37", ph_log[37], 0);
    check("ped2_e38", ph_log[38], 1);
    check("ped2_walk43", wk_log[43], 1);
    check("ped2_walk48", wk_log[48], 1);
    check("ped2_walk49", wk_log[49], 0);

    // Randomized traffic with occasional asynchronous resets.
    do_reset(1'b0);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) side_req = ~side_req;
      ped_req = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 499) == 0) begin
        ped_req = 1'b0;
        do_reset(1'b1);
      end else begin
        step();
      end
    end
    side_req = 1'b0;
    ped_req  = 1'b0;
    steps(2);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
